word_scan_ctrl: RTL

Sequences a parallel word, bit-serially and MSB-first, through an overlapping "1010" Mealy detector and reports the match results for that word. It sits between a parallel producer and the detector, and owns the start/busy/done handshake. It decides when the detector advances and when its state is cleared. With `cont` set, the detector state carries across consecutive words, so a pattern that spans a word boundary is still detected.

---
 rtl/word_scan_pkg.sv | 8 +
 rtl/seq_det_1010.sv | 23 ++
 rtl/word_scan_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/word_scan_pkg.sv
// word_scan_pkg: controller state type and "1010" detector state encodings shared by word_scan_ctrl and seq_det_1010
package word_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_state_e;
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;
endpackage

// File: rtl/seq_det_1010.sv
// seq_det_1010: overlapping "1010" Mealy detector
//   clk, rst (async active-low) | en: advance on bit_in | clr: force S0, wins over en
//   bit_in: serial input | hit: Mealy output (last three bits were "101" and bit_in is 0)
module seq_det_1010
  import word_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic bit_in,
  output logic hit
);
  logic [1:0] state_q, state_d, nxt;
  always_comb begin
    nxt = bit_in ? ((state_q == S2) ? S3 : S1) : ((state_q == S1 || state_q == S3) ? S2 : S0);
    state_d = clr ? S0 : (en ? nxt : state_q);
    hit = (state_q == S3) && !bit_in;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= S0;
    else state_q <= state_d;
endmodule

// File: rtl/word_scan_ctrl.sv
// word_scan_ctrl: shifts a parallel word MSB-first through a "1010" detector and reports hit count / first hit position
//   clk, rst (async active-low) | start, din, cont: scan request, word, keep-detector-state flag
//   busy: bits being shifted | done: one-cycle result strobe | match_cnt, first_pos: results of the last word
//   bit_out: serial bit presented to the detector | hit: detector output, only while busy
module word_scan_ctrl
  import word_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    match_cnt,
  output logic [CW-1:0]    first_pos,
  output logic             bit_out,
  output logic             hit
);
  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    idx_q, idx_d, cnt_q, cnt_d, pos_q, pos_d;
  logic             accept, det_hit;
  seq_det_1010 u_det (
    .clk    (clk),
    .rst    (rst),
    .en     (busy),
    .clr    (accept && !cont),
    .bit_in (bit_out),
    .hit    (det_hit)
  );
  // the register is fully shifted out by the end of a scan, so its MSB is 0 whenever not shifting
  assign bit_out   = sr_q[WIDTH-1];
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign hit       = busy && det_hit;
  assign match_cnt = cnt_q;
  assign first_pos = pos_q;
  assign accept    = start && (state_q != SHIFT);
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    if (busy) begin
      sr_d  = sr_q << 1;
      idx_d = idx_q + CW'(1);
      if (hit) begin
        cnt_d = cnt_q + CW'(1);
        pos_d = (pos_q == '0) ? idx_q + CW'(1) : pos_q;
      end
      if (idx_q == CW'(WIDTH - 1)) state_d = DONE;
    end else if (accept) begin
      state_d = SHIFT;
      sr_d    = din;
      idx_d   = '0;
      cnt_d   = '0;
      pos_d   = '0;
    end else if (done) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
endmodule
